// File: rtl/prbs_check_ctrl.sv
// -----------------------------------------------------------------------------
// prbs_check_ctrl
//   PRBS receive checker with lock control. A local predictor register is
//   seeded from the incoming stream, verified for VERIFY_LEN clean bits, then
//   free-runs for WINDOW bits while counting mismatches.
//
// Parameters
//   n          : PRBS register width (XNOR-feedback tap table, n = 3..32)
//   VERIFY_LEN : consecutive clean bits needed before lock
//   WINDOW     : bits checked in RUN before the test completes
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   single-cycle test request (honoured in IDLE/DONE)
//   abort        in   single-cycle stop request, any state -> IDLE
//   rx_valid     in   qualifies rx_bit
//   rx_bit       in   received PRBS bit
//   state_o      out  FSM state: IDLE=0 SEED=1 VERIFY=2 RUN=3 DONE=4
//   locked       out  high in RUN and DONE
//   done         out  high in DONE
//   bit_count    out  valid bits checked in RUN
//   err_count    out  mismatches in RUN, saturating
//   relock_count out  VERIFY failures since last start, saturating
// -----------------------------------------------------------------------------
module prbs_check_ctrl #(
  parameter int n          = 16,
  parameter int VERIFY_LEN = 64,
  parameter int WINDOW     = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        rx_valid,
  input  logic        rx_bit,
  output logic [2:0]  state_o,
  output logic        locked,
  output logic        done,
  output logic [31:0] bit_count,
  output logic [31:0] err_count,
  output logic [7:0]  relock_count
);

  // Number of feedback taps for width w; -1 marks an unsupported width.
  function automatic int lfsr_n_taps(input int w);
    case (w)
      3, 4, 5, 6, 7, 9, 10, 11, 15, 17, 18, 20, 21, 22, 23, 25, 28, 29, 31:
        return 2;
      8, 12, 13, 14, 16, 19, 24, 26, 27, 30, 32:
        return 4;
      default:
        return -1;
    endcase
  endfunction

  // Tap positions (1-based) packed as {t3, t2, t1, t0}, t0 in the low byte.
  function automatic logic [31:0] lfsr_tap_word(input int w);
    case (w)
      3:       return {8'd0,  8'd0,  8'd2,  8'd3};
      4:       return {8'd0,  8'd0,  8'd3,  8'd4};
      5:       return {8'd0,  8'd0,  8'd3,  8'd5};
      6:       return {8'd0,  8'd0,  8'd5,  8'd6};
      7:       return {8'd0,  8'd0,  8'd6,  8'd7};
      8:       return {8'd4,  8'd5,  8'd6,  8'd8};
      9:       return {8'd0,  8'd0,  8'd5,  8'd9};
      10:      return {8'd0,  8'd0,  8'd7,  8'd10};
      11:      return {8'd0,  8'd0,  8'd9,  8'd11};
      12:      return {8'd1,  8'd4,  8'd6,  8'd12};
      13:      return {8'd1,  8'd3,  8'd4,  8'd13};
      14:      return {8'd1,  8'd3,  8'd5,  8'd14};
      15:      return {8'd0,  8'd0,  8'd14, 8'd15};
      16:      return {8'd4,  8'd13, 8'd15, 8'd16};
      17:      return {8'd0,  8'd0,  8'd14, 8'd17};
      18:      return {8'd0,  8'd0,  8'd11, 8'd18};
      19:      return {8'd1,  8'd2,  8'd6,  8'd19};
      20:      return {8'd0,  8'd0,  8'd17, 8'd20};
      21:      return {8'd0,  8'd0,  8'd19, 8'd21};
      22:      return {8'd0,  8'd0,  8'd21, 8'd22};
      23:      return {8'd0,  8'd0,  8'd18, 8'd23};
      24:      return {8'd17, 8'd22, 8'd23, 8'd24};
      25:      return {8'd0,  8'd0,  8'd22, 8'd25};
      26:      return {8'd1,  8'd2,  8'd6,  8'd26};
      27:      return {8'd1,  8'd2,  8'd5,  8'd27};
      28:      return {8'd0,  8'd0,  8'd25, 8'd28};
      29:      return {8'd0,  8'd0,  8'd27, 8'd29};
      30:      return {8'd1,  8'd4,  8'd6,  8'd30};
      31:      return {8'd0,  8'd0,  8'd28, 8'd31};
      32:      return {8'd1,  8'd2,  8'd22, 8'd32};
      default: return '0;
    endcase
  endfunction

  // Bit mask over pred selecting pred[tap-1] for every tap of width w.
  function automatic logic [n-1:0] tap_mask(input int w);
    logic [n-1:0] m;
    logic [31:0]  tw;
    logic [31:0]  sh;
    int unsigned  pos;
    int           cnt;
    m   = '0;
    tw  = lfsr_tap_word(w);
    cnt = lfsr_n_taps(w);
    for (int unsigned k = 0; k < 4; k++) begin
      sh  = tw >> (8 * k);
      pos = {24'd0, sh[7:0]};
      if (int'(k) < cnt && pos >= 1 && pos <= unsigned'(w))
        m = m | (n'(1) << (pos - 1));
    end
    return m;
  endfunction

  localparam int           N_TAPS   = lfsr_n_taps(n);
  localparam logic [n-1:0] TAP_MASK = tap_mask(n);
  localparam int           SW       = $clog2(n + 1);
  localparam int           VW       = $clog2(VERIFY_LEN + 1);

  generate
    if (N_TAPS == -1) begin : g_bad_n
      $error("prbs_check_ctrl: no LFSR tap set for n=%0d", n);
    end
    if (VERIFY_LEN < 1) begin : g_bad_verify_len
      $error("prbs_check_ctrl: VERIFY_LEN must be >= 1");
    end
    if (WINDOW < 1) begin : g_bad_window
      $error("prbs_check_ctrl: WINDOW must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEED   = 3'd1,
    S_VERIFY = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         r_state;
  logic [n-1:0]   r_pred;
  logic [SW-1:0]  r_seed_cnt;
  logic [VW-1:0]  r_ver_cnt;
  logic [31:0]    r_bit_cnt;
  logic [31:0]    r_err_cnt;
  logic [7:0]     r_relock;
  logic           r_locked;
  logic           r_done;

  state_t         w_state_nx;
  logic [n-1:0]   w_pred_nx;
  logic [SW-1:0]  w_seed_nx;
  logic [VW-1:0]  w_ver_nx;
  logic [31:0]    w_bit_nx;
  logic [31:0]    w_err_nx;
  logic [7:0]     w_relock_nx;

  logic           w_exp;
  logic           w_mis;
  logic [n-1:0]   w_seed_shift;
  logic [n-1:0]   w_pred_shift;
  logic [31:0]    w_bit_inc;

  // XNOR feedback: expected bit is the inverted parity of the tapped bits.
  assign w_exp        = ~^(r_pred & TAP_MASK);
  assign w_mis        = rx_bit ^ w_exp;
  assign w_seed_shift = {r_pred[n-2:0], rx_bit};
  assign w_pred_shift = {r_pred[n-2:0], w_exp};
  assign w_bit_inc    = r_bit_cnt + 32'd1;

  always_comb begin
    w_state_nx  = r_state;
    w_pred_nx   = r_pred;
    w_seed_nx   = r_seed_cnt;
    w_ver_nx    = r_ver_cnt;
    w_bit_nx    = r_bit_cnt;
    w_err_nx    = r_err_cnt;
    w_relock_nx = r_relock;

    if (abort) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nx  = S_SEED;
            w_seed_nx   = '0;
            w_ver_nx    = '0;
            w_bit_nx    = '0;
            w_err_nx    = '0;
            w_relock_nx = '0;
          end
        end

        S_SEED: begin
          if (rx_valid) begin
            w_pred_nx = w_seed_shift;
            w_seed_nx = r_seed_cnt + SW'(1);
            if (r_seed_cnt == SW'(n - 1)) begin
              // An all-ones seed would lock the XNOR predictor; reseed instead.
              if (w_seed_shift == '1) begin
                w_seed_nx = '0;
              end else begin
                w_state_nx = S_VERIFY;
                w_ver_nx   = '0;
              end
            end
          end
        end

        S_VERIFY: begin
          if (rx_valid) begin
            w_pred_nx = w_pred_shift;
            if (w_mis) begin
              w_state_nx = S_SEED;
              w_seed_nx  = '0;
              w_ver_nx   = '0;
              if (r_relock != '1) w_relock_nx = r_relock + 8'd1;
            end else begin
              w_ver_nx = r_ver_cnt + VW'(1);
              if (r_ver_cnt == VW'(VERIFY_LEN - 1)) w_state_nx = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (rx_valid) begin
            w_pred_nx = w_pred_shift;
            w_bit_nx  = w_bit_inc;
            if (w_mis && r_err_cnt != '1) w_err_nx = r_err_cnt + 32'd1;
            if (w_bit_inc == 32'(WINDOW)) w_state_nx = S_DONE;
          end
        end

        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pred     <= '0;
      r_seed_cnt <= '0;
      r_ver_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_err_cnt  <= '0;
      r_relock   <= '0;
      r_locked   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pred     <= w_pred_nx;
      r_seed_cnt <= w_seed_nx;
      r_ver_cnt  <= w_ver_nx;
      r_bit_cnt  <= w_bit_nx;
      r_err_cnt  <= w_err_nx;
      r_relock   <= w_relock_nx;
      // Flags registered from the next state so they never decode live inputs.
      r_locked   <= (w_state_nx == S_RUN) || (w_state_nx == S_DONE);
      r_done     <= (w_state_nx == S_DONE);
    end
  end

  assign state_o      = r_state;
  assign locked       = r_locked;
  assign done         = r_done;
  assign bit_count    = r_bit_cnt;
  assign err_count    = r_err_cnt;
  assign relock_count = r_relock;

endmodule

// File: tb/tb_prbs_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prbs_check_ctrl
//   Bench for prbs_check_ctrl with n=7, VERIFY_LEN=16, WINDOW=1000. A local
//   XNOR LFSR (taps 7,6, init 2) produces the reference stream. Each vector
//   pushes its expected end-of-test results to a scoreboard queue; the entry
//   is popped and compared when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_prbs_check_ctrl;

  localparam int N  = 7;
  localparam int VL = 16;
  localparam int WN = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        rx_valid;
  logic        rx_bit;
  logic [2:0]  state_o;
  logic        locked;
  logic        done;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic [7:0]  relock_count;

  prbs_check_ctrl #(
    .n          (N),
    .VERIFY_LEN (VL),
    .WINDOW     (WN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .rx_valid     (rx_valid),
    .rx_bit       (rx_bit),
    .state_o      (state_o),
    .locked       (locked),
    .done         (done),
    .bit_count    (bit_count),
    .err_count    (err_count),
    .relock_count (relock_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit seed_ones;   // first N valid bits forced to 1
    bit rand_valid;  // rx_valid at 50 %
    int inv_at;      // valid-bit index (from start) to invert, -1 = none
    int exp_valid;   // valid bits consumed until done
    int exp_err;
    int exp_bits;
    int exp_relock;
  } vec_t;

  vec_t vecs[5];
  vec_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] gen;
  int         sent;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic gen_step();
    logic fb;
    fb  = ~(gen[6] ^ gen[5]);
    gen = {gen[5:0], fb};
    return fb;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gen  = 7'd2;
    sent = 0;
  endtask

  // Clean valid bits until 'upto' have been sent, optionally inverting one.
  task automatic send_stream(input int upto, input int inv_at);
    int guard;
    logic b;
    guard = 0;
    while (sent < upto && guard < 5000) begin
      b = gen_step();
      if (sent == inv_at) b = ~b;
      rx_valid = 1'b1;
      rx_bit   = b;
      @(posedge clk); #1;
      sent++;
      guard++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    logic b;
    vec_t e;
    apply_reset();
    pulse_start();
    chk("start_to_seed", 64'(state_o), 64'd1);
    sb_q.push_back(v);
    cyc = 0;
    while (!done && cyc < 5000) begin
      rx_valid = v.rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rx_valid) begin
        if (v.seed_ones && sent < N) b = 1'b1;
        else b = gen_step();
        if (sent == v.inv_at) b = ~b;
        rx_bit = b;
      end else begin
        rx_bit = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (rx_valid) begin
        sent++;
        if (v.id == 0 && sent == N)      chk("seed_to_verify", 64'(state_o), 64'd2);
        if (v.id == 0 && sent == N + VL) chk("verify_to_run", 64'(state_o), 64'd3);
        if (v.id == 0 && sent == N + VL) chk("locked_in_run", 64'(locked), 64'd1);
        if (v.seed_ones && sent == N)    chk("allones_stays_seed", 64'(state_o), 64'd1);
      end
      cyc++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL vec%0d_timeout: got done=0 expected done=1 within 5000 cycles", v.id);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL vec%0d_scoreboard: got empty queue expected 1 entry", v.id);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_state", e.id),  64'(state_o),      64'd4);
      chk($sformatf("vec%0d_locked", e.id), 64'(locked),       64'd1);
      chk($sformatf("vec%0d_valid", e.id),  64'(sent),         64'(e.exp_valid));
      chk($sformatf("vec%0d_bits", e.id),   64'(bit_count),    64'(e.exp_bits));
      chk($sformatf("vec%0d_errs", e.id),   64'(err_count),    64'(e.exp_err));
      chk($sformatf("vec%0d_relock", e.id), 64'(relock_count), 64'(e.exp_relock));
    end
  endtask

  initial begin
    //          id seed1 rnd inv_at      valid         err bits relock
    vecs[0] = '{0, 1'b0, 1'b0, -1,          N + VL + WN,   0, WN, 0};
    vecs[1] = '{1, 1'b0, 1'b0, N + VL + 500, N + VL + WN,  1, WN, 0};
    vecs[2] = '{2, 1'b0, 1'b0, N + 5,       N + 6 + N + VL + WN, 0, WN, 1};
    vecs[3] = '{3, 1'b1, 1'b0, -1,          N + N + VL + WN, 0, WN, 0};
    vecs[4] = '{4, 1'b0, 1'b1, -1,          N + VL + WN,   0, WN, 0};

    // Asynchronous reset before any clock edge.
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
    #3;
    chk("reset_state",  64'(state_o),      64'd0);
    chk("reset_bits",   64'(bit_count),    64'd0);
    chk("reset_errs",   64'(err_count),    64'd0);
    chk("reset_relock", 64'(relock_count), 64'd0);
    chk("reset_locked", 64'(locked),       64'd0);
    chk("reset_done",   64'(done),         64'd0);
    @(negedge clk);
    rst = 1'b0;
    // No start: valid traffic must not move the FSM out of IDLE.
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("idle_without_start", 64'(state_o), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // start and abort together in DONE: abort wins, counters hold.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_state", 64'(state_o),   64'd0);
    chk("start_abort_done",  64'(done),      64'd0);
    chk("start_abort_lock",  64'(locked),    64'd0);
    chk("start_abort_bits",  64'(bit_count), 64'(WN));
    @(negedge clk);

    // Start ignored in RUN; abort at RUN bit 300 holds counters.
    apply_reset();
    pulse_start();
    send_stream(N + VL + 100, -1);
    chk("run_bits_100", 64'(bit_count), 64'd100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_ignored_run", 64'(state_o), 64'd3);
    @(negedge clk);
    send_stream(N + VL + 300, -1);
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_bit   = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    rx_valid = 1'b0;
    chk("abort_state",  64'(state_o),   64'd0);
    chk("abort_bits",   64'(bit_count), 64'd300);
    chk("abort_locked", 64'(locked),    64'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("abort_hold_bits",  64'(bit_count), 64'd300);
    chk("abort_hold_state", 64'(state_o),   64'd0);

    // Mid-RUN asynchronous reset after one relock, between clock edges.
    apply_reset();
    pulse_start();
    send_stream(N + 3 + N + VL + 190, N + 2);
    chk("pre_rst_state",  64'(state_o),      64'd3);
    chk("pre_rst_relock", 64'(relock_count), 64'd1);
    chk("pre_rst_bits",   64'(bit_count),    64'd190);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_state",  64'(state_o),      64'd0);
    chk("midrun_rst_bits",   64'(bit_count),    64'd0);
    chk("midrun_rst_errs",   64'(err_count),    64'd0);
    chk("midrun_rst_relock", 64'(relock_count), 64'd0);
    chk("midrun_rst_locked", 64'(locked),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
